riscv_mini_core: RTL and testbench
==================================

// Module: riscv_mini_core
// PURPOSE
// - Multi-cycle, non-pipelined RV32I integer core with separate instruction and data request/response ports.
// - Sits between the SoC reset/ID straps and the I/D memory subsystem (caches or TCM).
// - Subset: LUI, AUIPC, JAL, JALR, BRANCH, LOAD/STORE (B/H/W, signed and unsigned), OP-IMM, OP, FENCE, FENCE.I.
// PARAMETERS
// - CACHEABLE_MASK  32'h8000_0000  mem_d_cacheable_o = |(mem_d_addr_o & CACHEABLE_MASK)
// PORTS
// - clk_i              in   1   single clock, all logic on rising edge
// - rst_ni             in   1   asynchronous, active-low reset
// - reset_vector_i     in   32  first fetch address, sampled in the RESET state
// - cpu_id_i           in   32  hart ID (mhartid when RISCV_MINI_CORE_CSR_EN)
// - intr_i             in   1   reserved; ignored
// - mem_i_rd_o         out  1   fetch request
// - mem_i_pc_o         out  32  fetch address, word aligned
// - mem_i_accept_i     in   1   fetch request taken
// - mem_i_valid_i      in   1   fetch response valid
// - mem_i_inst_i       in   32  fetched instruction
// - mem_i_error_i      in   1   fetch bus error, qualified by valid
// - mem_i_flush_o, mem_i_invalidate_o  out  1  one-cycle pulses, see FENCE
// - mem_d_addr_o       out  32  data address
// - mem_d_data_wr_o    out  32  store data, lane-replicated
// - mem_d_rd_o         out  1   load request
// - mem_d_wr_o         out  4   store byte enables
// - mem_d_cacheable_o  out  1   see CACHEABLE_MASK
// - mem_d_req_tag_o    out  11  {6'b0, rd}
// - mem_d_accept_i     in   1   data request taken
// - mem_d_ack_i        in   1   data response valid
// - mem_d_data_rd_i    in   32  load data
// - mem_d_error_i      in   1   data bus error, qualified by ack
// - mem_d_resp_tag_i   in   11  ignored
// - mem_d_flush_o, mem_d_writeback_o, mem_d_invalidate_o  out  1  one-cycle pulses, see FENCE
// BEHAVIOUR
// - Reset: all outputs 0, pc=0, x1..x31=0, state RESET. x0 reads 0 always; writes to x0 are discarded.
// - FSM: RESET->FETCH (pc<=reset_vector_i). FETCH: mem_i_rd_o=1, held until mem_i_accept_i, then WAIT_I.
// - WAIT_I waits for mem_i_valid_i and latches the instruction. error -> FAULT; otherwise EXEC.
// - EXEC (1 cycle): decode and ALU. ALU/branch/jump ops write rd, update pc, then FETCH.
// - EXEC, load/store: go to MEM. Misaligned jump/branch target, misaligned access, or unknown opcode -> FAULT.
// - MEM: hold rd/wr, addr and data stable until mem_d_accept_i, then WAIT_D.
// - WAIT_D: on mem_d_ack_i, load result is lane-extracted and sign/zero-extended into rd; pc+=4; FETCH. mem_d_error_i -> FAULT.
// - FAULT: no further requests; exit only by reset. Reset mid-transaction drops it.
// - Store lanes: SB wr=1<<addr[1:0], data={4{rs2[7:0]}}; SH wr=3<<addr[1:0], data={2{rs2[15:0]}}; SW wr=4'hF.
// - Data request address is rs1+imm, full byte address; mem_i_pc_o={pc[31:2],2'b00}.
// - Arithmetic mod 2^32; shift amount is [4:0]; SLT signed, SLTU unsigned; branch target pc+imm, pc-relative to the branch.
// - FENCE: pulse mem_d_flush_o 1 cycle, then FETCH. FENCE.I: pulse mem_d_writeback_o and mem_i_invalidate_o 1 cycle, then FETCH.
// - mem_i_flush_o, mem_d_invalidate_o: held 0.
// - Responses arriving outside WAIT_I/WAIT_D are ignored. At most one outstanding request per port.
// CONFIGURATION
// - RISCV_MINI_CORE_CSR_EN defined: CSRRW/CSRRS/CSRRC (reg and imm forms) read-only.
//   - CSR 0xF14 = cpu_id_i; CSR 0xB00 = free-running 32-bit cycle counter, reset 0.
//   - Writes are ignored. Any other CSR address -> FAULT.
// - Undefined: every SYSTEM opcode -> FAULT, and no counter is built.
// TESTING
// - reset_vector_i=0x8000_0000, release rst_ni -> first mem_i_rd_o with mem_i_pc_o=0x8000_0000; accept stall of 3 cycles holds request stable.
// - ADDI x1,x0,5; ADDI x2,x1,-7; SW x2,0(x0) -> mem_d_wr_o=4'hF, mem_d_addr_o=0, mem_d_data_wr_o=0xFFFF_FFFE.
// - SB x2,3(x0) -> wr=4'b1000, data=0xFEFE_FEFE. LB x3 on load data 0x8000_0000 at addr 3 -> x3=0xFFFF_FF80. LBU -> x3=0x80.
// - BEQ x0,x0,-8 at 0x8000_0010 -> next fetch 0x8000_0008. JAL x1,+16 -> x1=pc+4, fetch pc+16.
// - mem_d_error_i with ack, or opcode 0x0000_0000 -> no further mem_i_rd_o until reset.
// - With RISCV_MINI_CORE_CSR_EN and cpu_id_i=0x5: CSRRS x4,0xF14,x0 -> x4=5. Without the macro -> FAULT.

Source files
------------

// File: rtl/riscv_mini_core_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mini_core_if
// Description : Instruction- and data-port bundle between riscv_mini_core
//               (master) and its memory subsystem (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_mini_core_if;
    // Instruction port
    logic        mem_i_rd_o;
    logic [31:0] mem_i_pc_o;
    logic        mem_i_flush_o;
    logic        mem_i_invalidate_o;
    logic        mem_i_accept_i;
    logic        mem_i_valid_i;
    logic [31:0] mem_i_inst_i;
    logic        mem_i_error_i;
    // Data port
    logic [31:0] mem_d_addr_o;
    logic [31:0] mem_d_data_wr_o;
    logic        mem_d_rd_o;
    logic [3:0]  mem_d_wr_o;
    logic        mem_d_cacheable_o;
    logic [10:0] mem_d_req_tag_o;
    logic        mem_d_flush_o;
    logic        mem_d_writeback_o;
    logic        mem_d_invalidate_o;
    logic        mem_d_accept_i;
    logic        mem_d_ack_i;
    logic [31:0] mem_d_data_rd_i;
    logic        mem_d_error_i;
    logic [10:0] mem_d_resp_tag_i;

    modport master (
        output mem_i_rd_o, mem_i_pc_o, mem_i_flush_o, mem_i_invalidate_o,
        input  mem_i_accept_i, mem_i_valid_i, mem_i_inst_i, mem_i_error_i,
        output mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
        output mem_d_cacheable_o, mem_d_req_tag_o, mem_d_flush_o,
        output mem_d_writeback_o, mem_d_invalidate_o,
        input  mem_d_accept_i, mem_d_ack_i, mem_d_data_rd_i, mem_d_error_i,
        input  mem_d_resp_tag_i
    );

    modport slave (
        input  mem_i_rd_o, mem_i_pc_o, mem_i_flush_o, mem_i_invalidate_o,
        output mem_i_accept_i, mem_i_valid_i, mem_i_inst_i, mem_i_error_i,
        input  mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
        input  mem_d_cacheable_o, mem_d_req_tag_o, mem_d_flush_o,
        input  mem_d_writeback_o, mem_d_invalidate_o,
        output mem_d_accept_i, mem_d_ack_i, mem_d_data_rd_i, mem_d_error_i,
        output mem_d_resp_tag_i
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mini_core.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mini_core
// Description : Multi-cycle, non-pipelined RV32I core (LUI, AUIPC, JAL, JALR,
//               branches, loads/stores, OP-IMM, OP, FENCE, FENCE.I).
//               Optional read-only CSRs (mhartid 0xF14, cycle 0xB00) when the
//               macro RISCV_MINI_CORE_CSR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mini_core #(
    parameter logic [31:0] CACHEABLE_MASK = 32'h8000_0000
) (
    input  wire               clk_i,
    input  wire               rst_ni,
    input  wire [31:0]        reset_vector_i,
    input  wire [31:0]        cpu_id_i,
    input  wire               intr_i,
    riscv_mini_core_if.master bus
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_RESET, ST_FETCH, ST_WAIT_I, ST_EXEC, ST_MEM, ST_WAIT_D, ST_FAULT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_inst, r_d_addr, r_d_wdata;
    logic [3:0]  r_d_be;
    logic        r_d_load;
    logic [31:0] r_regs [0:31];

    // Instruction fields and immediates, all taken from the latched instruction
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1v, w_rs2v, w_alu_b, w_alu, w_d_addr, w_ld_shift, w_ld_data;
    logic [31:0] w_wb_data, w_pc_nxt, w_wdata;
    logic [3:0]  w_be;
    logic        w_fault, w_wb_en, w_is_mem, w_is_load, w_fence, w_fence_i, w_br_take;

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_f3     = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_imm_i  = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_imm_s  = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_imm_b  = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_imm_u  = {r_inst[31:12], 12'h000};
    assign w_imm_j  = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
    assign w_rs1v   = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2v   = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];
    assign w_alu_b  = (w_opcode == c_OP_REG) ? w_rs2v : w_imm_i;
    assign w_d_addr = w_rs1v + ((w_opcode == c_OP_STORE) ? w_imm_s : w_imm_i);

`ifdef RISCV_MINI_CORE_CSR_EN
    logic [31:0] r_cycle;

    // Free-running cycle counter exposed as CSR 0xB00
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_cycle <= 32'h0;
        else         r_cycle <= r_cycle + 32'd1;
    end

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, intr_i, bus.mem_d_resp_tag_i};
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, intr_i, bus.mem_d_resp_tag_i, cpu_id_i};
`endif

    // Integer ALU shared by OP and OP-IMM; SUB/SRA only exist in the register form / shift form
    always_comb begin
        w_alu = 32'h0;
        case (w_f3)
            3'd0: w_alu = (w_opcode == c_OP_REG && r_inst[30]) ? (w_rs1v - w_alu_b) : (w_rs1v + w_alu_b);
            3'd1: w_alu = w_rs1v << w_alu_b[4:0];
            3'd2: w_alu = {31'h0, $signed(w_rs1v) < $signed(w_alu_b)};
            3'd3: w_alu = {31'h0, w_rs1v < w_alu_b};
            3'd4: w_alu = w_rs1v ^ w_alu_b;
            3'd5: w_alu = r_inst[30] ? 32'($signed(w_rs1v) >>> w_alu_b[4:0]) : (w_rs1v >> w_alu_b[4:0]);
            3'd6: w_alu = w_rs1v | w_alu_b;
            default: w_alu = w_rs1v & w_alu_b;
        endcase
    end

    // Decode: write-back, next pc, memory request shape and fault detection
    always_comb begin
        w_fault   = 1'b0;
        w_wb_en   = 1'b0;
        w_wb_data = 32'h0;
        w_pc_nxt  = r_pc + 32'd4;
        w_is_mem  = 1'b0;
        w_is_load = 1'b0;
        w_be      = 4'h0;
        w_wdata   = 32'h0;
        w_fence   = 1'b0;
        w_fence_i = 1'b0;
        w_br_take = 1'b0;
        case (w_opcode)
            c_OP_LUI:   begin w_wb_en = 1'b1; w_wb_data = w_imm_u; end
            c_OP_AUIPC: begin w_wb_en = 1'b1; w_wb_data = r_pc + w_imm_u; end
            c_OP_JAL: begin
                w_wb_en = 1'b1; w_wb_data = r_pc + 32'd4;
                w_pc_nxt = r_pc + w_imm_j;
                w_fault = (w_pc_nxt[1:0] != 2'b00);
            end
            c_OP_JALR: begin
                w_wb_en = 1'b1; w_wb_data = r_pc + 32'd4;
                w_pc_nxt = (w_rs1v + w_imm_i) & ~32'd1;
                w_fault = w_pc_nxt[1];
            end
            c_OP_BRANCH: begin
                case (w_f3)
                    3'd0: w_br_take = (w_rs1v == w_rs2v);
                    3'd1: w_br_take = (w_rs1v != w_rs2v);
                    3'd4: w_br_take = ($signed(w_rs1v) <  $signed(w_rs2v));
                    3'd5: w_br_take = ($signed(w_rs1v) >= $signed(w_rs2v));
                    3'd6: w_br_take = (w_rs1v <  w_rs2v);
                    3'd7: w_br_take = (w_rs1v >= w_rs2v);
                    default: w_fault = 1'b1;
                endcase
                if (w_br_take) begin
                    w_pc_nxt = r_pc + w_imm_b;
                    w_fault  = (w_pc_nxt[1:0] != 2'b00);
                end
            end
            c_OP_LOAD: begin
                w_is_mem = 1'b1; w_is_load = 1'b1;
                case (w_f3)
                    3'd0, 3'd4: w_fault = 1'b0;
                    3'd1, 3'd5: w_fault = w_d_addr[0];
                    3'd2:       w_fault = (w_d_addr[1:0] != 2'b00);
                    default:    w_fault = 1'b1;
                endcase
            end
            c_OP_STORE: begin
                w_is_mem = 1'b1;
                case (w_f3)
                    3'd0: begin w_be = 4'b0001 << w_d_addr[1:0]; w_wdata = {4{w_rs2v[7:0]}}; end
                    3'd1: begin
                        w_be = 4'b0011 << w_d_addr[1:0]; w_wdata = {2{w_rs2v[15:0]}};
                        w_fault = w_d_addr[0];
                    end
                    3'd2: begin w_be = 4'hF; w_wdata = w_rs2v; w_fault = (w_d_addr[1:0] != 2'b00); end
                    default: w_fault = 1'b1;
                endcase
            end
            c_OP_IMM, c_OP_REG: begin w_wb_en = 1'b1; w_wb_data = w_alu; end
            c_OP_FENCE: begin
                case (w_f3)
                    3'd0:    w_fence   = 1'b1;
                    3'd1:    w_fence_i = 1'b1;
                    default: w_fault   = 1'b1;
                endcase
            end
`ifdef RISCV_MINI_CORE_CSR_EN
            c_OP_SYSTEM: begin
                // CSR instructions read only; funct3 0 (ECALL/EBREAK) and 4 are not supported
                if (w_f3 == 3'd0 || w_f3 == 3'd4)       w_fault = 1'b1;
                else if (r_inst[31:20] == 12'hF14) begin w_wb_en = 1'b1; w_wb_data = cpu_id_i; end
                else if (r_inst[31:20] == 12'hB00) begin w_wb_en = 1'b1; w_wb_data = r_cycle; end
                else                                     w_fault = 1'b1;
            end
`endif
            default: w_fault = 1'b1;
        endcase
    end

    // Load lane extraction and sign/zero extension
    assign w_ld_shift = bus.mem_d_data_rd_i >> {r_d_addr[1:0], 3'b000};
    always_comb begin
        w_ld_data = w_ld_shift;
        case (w_f3)
            3'd0: w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'd1: w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'd4: w_ld_data = {24'h0, w_ld_shift[7:0]};
            3'd5: w_ld_data = {16'h0, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_RESET;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_FETCH;
            ST_FETCH:  if (bus.mem_i_accept_i) w_state_nxt = ST_WAIT_I;
            ST_WAIT_I: if (bus.mem_i_valid_i) w_state_nxt = bus.mem_i_error_i ? ST_FAULT : ST_EXEC;
            ST_EXEC:   w_state_nxt = w_fault ? ST_FAULT : (w_is_mem ? ST_MEM : ST_FETCH);
            ST_MEM:    if (bus.mem_d_accept_i) w_state_nxt = ST_WAIT_D;
            ST_WAIT_D: if (bus.mem_d_ack_i) w_state_nxt = bus.mem_d_error_i ? ST_FAULT : ST_FETCH;
            ST_FAULT:  w_state_nxt = ST_FAULT;
            default:   w_state_nxt = ST_FAULT;
        endcase
    end

    // Architectural state: pc, instruction latch, register file, data request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc      <= 32'h0;
            r_inst    <= 32'h0;
            r_d_addr  <= 32'h0;
            r_d_wdata <= 32'h0;
            r_d_be    <= 4'h0;
            r_d_load  <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else begin
            case (r_state)
                ST_RESET:  r_pc <= reset_vector_i;
                ST_WAIT_I: if (bus.mem_i_valid_i && !bus.mem_i_error_i) r_inst <= bus.mem_i_inst_i;
                ST_EXEC: begin
                    if (!w_fault && w_is_mem) begin
                        r_d_addr  <= w_d_addr;
                        r_d_wdata <= w_wdata;
                        r_d_be    <= w_be;
                        r_d_load  <= w_is_load;
                    end else if (!w_fault) begin
                        r_pc <= w_pc_nxt;
                        if (w_wb_en && w_rd != 5'd0) r_regs[w_rd] <= w_wb_data;
                    end
                end
                ST_WAIT_D: begin
                    if (bus.mem_d_ack_i && !bus.mem_d_error_i) begin
                        if (r_d_load && w_rd != 5'd0) r_regs[w_rd] <= w_ld_data;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_i_rd_o         = (r_state == ST_FETCH);
    assign bus.mem_i_pc_o         = {r_pc[31:2], 2'b00};
    assign bus.mem_i_flush_o      = 1'b0;
    assign bus.mem_i_invalidate_o = (r_state == ST_EXEC) && w_fence_i;
    assign bus.mem_d_addr_o       = r_d_addr;
    assign bus.mem_d_data_wr_o    = r_d_wdata;
    assign bus.mem_d_rd_o         = (r_state == ST_MEM) && r_d_load;
    assign bus.mem_d_wr_o         = (r_state == ST_MEM) ? r_d_be : 4'h0;
    assign bus.mem_d_cacheable_o  = |(r_d_addr & CACHEABLE_MASK);
    assign bus.mem_d_req_tag_o    = {6'b000000, w_rd};
    assign bus.mem_d_flush_o      = (r_state == ST_EXEC) && w_fence;
    assign bus.mem_d_writeback_o  = (r_state == ST_EXEC) && w_fence_i;
    assign bus.mem_d_invalidate_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mini_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mini_core
// Description : Directed self-checking bench for riscv_mini_core. Acts as the
//               I/D memory, feeds a hand-assembled program and checks fetch
//               addresses and data requests against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mini_core;
    localparam logic [31:0] c_BASE = 32'h8000_0000;
    localparam int c_OP_IMM = 7'h13, c_OP_REG = 7'h33, c_LOAD = 7'h03, c_STORE = 7'h23;
    localparam int c_BRANCH = 7'h63, c_JAL = 7'h6F, c_JALR = 7'h67, c_LUI = 7'h37;
    localparam int c_AUIPC = 7'h17, c_FENCE = 7'h0F, c_SYSTEM = 7'h73;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] data;
        logic        rd;
        logic [4:0]  rd_reg;
        logic        cache;
    } dreq_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] reset_vector_i = c_BASE;
    logic [31:0] cpu_id_i = 32'h5;
    logic        intr_i = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] q_i[$];
    dreq_t       q_d[$];

    riscv_mini_core_if bus();

    riscv_mini_core #(.CACHEABLE_MASK(32'h8000_0000)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .reset_vector_i(reset_vector_i),
        .cpu_id_i(cpu_id_i), .intr_i(intr_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic dreq_t mk_st(logic [31:0] a, logic [3:0] w, logic [31:0] d);
        dreq_t r;
        r.addr = a; r.wr = w; r.data = d; r.rd = 1'b0; r.rd_reg = 5'd0; r.cache = a[31];
        return r;
    endfunction
    function automatic dreq_t mk_ld(logic [31:0] a, logic [4:0] rd);
        dreq_t r;
        r.addr = a; r.wr = 4'h0; r.data = 32'h0; r.rd = 1'b1; r.rd_reg = rd; r.cache = a[31];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Serve one fetch: expected address from the scoreboard, optional accept stall
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] inst, input int stall);
        logic [31:0] e;
        int n;
        q_i.push_back(exp_pc);
        n = 0;
        while (!bus.mem_i_rd_o && n < 40) begin @(negedge clk_i); n++; end
        e = q_i.pop_front();
        if (!bus.mem_i_rd_o) begin
            check("fetch_timeout", 32'h0, 32'h1);
            return;
        end
        check("fetch_pc", bus.mem_i_pc_o, e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            check("fetch_hold", bus.mem_i_rd_o ? bus.mem_i_pc_o : 32'hDEAD_DEAD, e);
        end
        bus.mem_i_accept_i = 1'b1;
        @(negedge clk_i);
        bus.mem_i_accept_i = 1'b0;
        bus.mem_i_valid_i  = 1'b1;
        bus.mem_i_inst_i   = inst;
        @(negedge clk_i);
        bus.mem_i_valid_i  = 1'b0;
    endtask

    // Serve one data access with a one-cycle accept stall
    task automatic do_data(input dreq_t exp, input logic [31:0] rdata, input logic err);
        dreq_t e;
        int n;
        q_d.push_back(exp);
        n = 0;
        while (!(bus.mem_d_rd_o || (bus.mem_d_wr_o != 4'h0)) && n < 40) begin @(negedge clk_i); n++; end
        e = q_d.pop_front();
        if (!(bus.mem_d_rd_o || (bus.mem_d_wr_o != 4'h0))) begin
            check("data_timeout", 32'h0, 32'h1);
            return;
        end
        check("d_addr", bus.mem_d_addr_o, e.addr);
        check("d_wr", {28'h0, bus.mem_d_wr_o}, {28'h0, e.wr});
        check("d_rd", {31'h0, bus.mem_d_rd_o}, {31'h0, e.rd});
        check("d_cacheable", {31'h0, bus.mem_d_cacheable_o}, {31'h0, e.cache});
        if (e.wr != 4'h0) check("d_wdata", bus.mem_d_data_wr_o, e.data);
        if (e.rd) check("d_tag", {21'h0, bus.mem_d_req_tag_o}, {27'h0, e.rd_reg});
        @(negedge clk_i);
        check("d_hold", {bus.mem_d_addr_o[27:0], bus.mem_d_wr_o}, {e.addr[27:0], e.wr});
        bus.mem_d_accept_i = 1'b1;
        @(negedge clk_i);
        bus.mem_d_accept_i  = 1'b0;
        bus.mem_d_ack_i     = 1'b1;
        bus.mem_d_data_rd_i = rdata;
        bus.mem_d_error_i   = err;
        @(negedge clk_i);
        bus.mem_d_ack_i     = 1'b0;
        bus.mem_d_error_i   = 1'b0;
    endtask

    task automatic expect_no_fetch(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            if (bus.mem_i_rd_o) seen = 1'b1;
        end
        check(tag, {31'h0, seen}, 32'h0);
    endtask

    initial begin
        bus.mem_i_accept_i = 1'b0; bus.mem_i_valid_i = 1'b0; bus.mem_i_inst_i = 32'h0;
        bus.mem_i_error_i = 1'b0;  bus.mem_d_accept_i = 1'b0; bus.mem_d_ack_i = 1'b0;
        bus.mem_d_data_rd_i = 32'h0; bus.mem_d_error_i = 1'b0; bus.mem_d_resp_tag_i = 11'h0;

        repeat (3) @(negedge clk_i);
        check("rst_i_rd", {31'h0, bus.mem_i_rd_o}, 32'h0);
        check("rst_pc", bus.mem_i_pc_o, 32'h0);
        check("rst_d", {bus.mem_d_addr_o[27:0], bus.mem_d_wr_o}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        do_fetch(c_BASE + 32'h00, enc_i(5, 0, 0, 1, c_OP_IMM), 3);       // ADDI x1,x0,5
        do_fetch(c_BASE + 32'h04, enc_i(-7, 1, 0, 2, c_OP_IMM), 0);      // ADDI x2,x1,-7
        do_fetch(c_BASE + 32'h08, enc_s(0, 2, 0, 2), 0);                 // SW x2,0(x0)
        do_data(mk_st(32'h0, 4'hF, 32'hFFFF_FFFE), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h0C, enc_s(3, 2, 0, 0), 0);                 // SB x2,3(x0)
        do_data(mk_st(32'h3, 4'b1000, 32'hFEFE_FEFE), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h10, enc_i(3, 0, 0, 3, c_LOAD), 0);         // LB x3,3(x0)
        do_data(mk_ld(32'h3, 5'd3), 32'h8000_0000, 1'b0);
        do_fetch(c_BASE + 32'h14, enc_s(0, 3, 0, 2), 0);                 // SW x3,0(x0)
        do_data(mk_st(32'h0, 4'hF, 32'hFFFF_FF80), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h18, enc_i(3, 0, 4, 3, c_LOAD), 0);         // LBU x3,3(x0)
        do_data(mk_ld(32'h3, 5'd3), 32'h8000_0000, 1'b0);
        do_fetch(c_BASE + 32'h1C, enc_s(0, 3, 0, 2), 0);                 // SW x3,0(x0)
        do_data(mk_st(32'h0, 4'hF, 32'h0000_0080), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h20, enc_b(-8, 0, 0, 0), 0);                // BEQ x0,x0,-8
        do_fetch(c_BASE + 32'h18, enc_j(16, 1), 0);                      // JAL x1,+16
        do_fetch(c_BASE + 32'h28, enc_s(-2048, 1, 0, 2), 0);             // SW x1,-2048(x0)
        do_data(mk_st(32'hFFFF_F800, 4'hF, 32'h8000_001C), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h2C, enc_r(0, 2, 1, 2, 6), 0);              // SLT  x6,x1,x2 -> 1
        do_fetch(c_BASE + 32'h30, enc_r(0, 1, 2, 3, 5), 0);              // SLTU x5,x2,x1 -> 0
        do_fetch(c_BASE + 32'h34, enc_i(4, 6, 1, 6, c_OP_IMM), 0);       // SLLI x6,x6,4 -> 16
        do_fetch(c_BASE + 32'h38, enc_r(32, 6, 5, 0, 7), 0);             // SUB x7,x5,x6
        do_fetch(c_BASE + 32'h3C, enc_s(8, 7, 0, 2), 0);                 // SW x7,8(x0)
        do_data(mk_st(32'h8, 4'hF, 32'hFFFF_FFF0), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h40, enc_i(32'h402, 7, 5, 8, c_OP_IMM), 0); // SRAI x8,x7,2
        do_fetch(c_BASE + 32'h44, enc_u(32'h12345, 9, c_LUI), 0);        // LUI x9,0x12345
        do_fetch(c_BASE + 32'h48, enc_r(0, 8, 9, 4, 9), 0);              // XOR x9,x9,x8
        do_fetch(c_BASE + 32'h4C, enc_s(12, 9, 0, 2), 0);                // SW x9,12(x0)
        do_data(mk_st(32'hC, 4'hF, 32'hEDCB_AFFC), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h50, enc_u(1, 10, c_AUIPC), 0);             // AUIPC x10,1
        do_fetch(c_BASE + 32'h54, enc_s(6, 10, 0, 1), 0);                // SH x10,6(x0)
        do_data(mk_st(32'h6, 4'b1100, 32'h1050_1050), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h58, enc_i(32'h44, 1, 0, 11, c_JALR), 0);   // JALR x11,0x44(x1)
        do_fetch(c_BASE + 32'h60, enc_s(16, 11, 0, 2), 0);               // SW x11,16(x0)
        do_data(mk_st(32'h10, 4'hF, 32'h8000_005C), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h64, enc_i(6, 0, 1, 12, c_LOAD), 0);        // LH x12,6(x0)
        do_data(mk_ld(32'h6, 5'd12), 32'h8001_0000, 1'b0);
        do_fetch(c_BASE + 32'h68, enc_s(20, 12, 0, 2), 0);               // SW x12,20(x0)
        do_data(mk_st(32'h14, 4'hF, 32'hFFFF_8001), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h6C, enc_b(64, 0, 0, 1), 0);                // BNE x0,x0 (not taken)
        do_fetch(c_BASE + 32'h70, enc_i(0, 0, 0, 0, c_FENCE), 0);        // FENCE
        check("fence_flush", {29'h0, bus.mem_d_flush_o, bus.mem_d_writeback_o, bus.mem_i_invalidate_o}, 32'h4);
        @(negedge clk_i);
        check("fence_flush_end", {31'h0, bus.mem_d_flush_o}, 32'h0);
        do_fetch(c_BASE + 32'h74, enc_i(0, 0, 1, 0, c_FENCE), 0);        // FENCE.I
        check("fencei_pulse", {29'h0, bus.mem_d_flush_o, bus.mem_d_writeback_o, bus.mem_i_invalidate_o}, 32'h3);
        @(negedge clk_i);
        check("fencei_end", {30'h0, bus.mem_d_writeback_o, bus.mem_i_invalidate_o}, 32'h0);
        do_fetch(c_BASE + 32'h78, enc_i(32'hF14, 0, 2, 4, c_SYSTEM), 0); // CSRRS x4,0xF14,x0
`ifdef RISCV_MINI_CORE_CSR_EN
        do_fetch(c_BASE + 32'h7C, enc_s(24, 4, 0, 2), 0);                // SW x4,24(x0)
        do_data(mk_st(32'h18, 4'hF, 32'h0000_0005), 32'h0, 1'b0);
        do_fetch(c_BASE + 32'h80, enc_i(0, 0, 2, 14, c_LOAD), 0);        // LW x14,0(x0) -> bus error
        do_data(mk_ld(32'h0, 5'd14), 32'h0, 1'b1);
        expect_no_fetch("fault_d_error");
`else
        expect_no_fetch("fault_csr_disabled");
`endif

        // Reset out of FAULT, then an all-zero opcode must fault again
        rst_ni = 1'b0;
        reset_vector_i = 32'h0000_0100;
        @(negedge clk_i);
        check("rst2_outputs", {30'h0, bus.mem_i_rd_o, bus.mem_d_rd_o}, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_fetch(32'h0000_0100, 32'h0000_0000, 1);
        expect_no_fetch("fault_opcode_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
